cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase instruction sequencer for the 8-bit
// accumulator CPU, with halt latching and single-step debug handshake.
//
// Ports:
//   clk, rst (sync, active-high)
//   opcode[2:0], zero            : IR opcode and accumulator-zero flag
//   step_en, step, resume        : debug single-step / halt release
//   sel, rd, ld_ir, inc_pc,
//   ld_pc, ld_ac, wr, data_e     : per-phase datapath strobes
//   halt, halted, phase[2:0]     : status
// Optional (define SEQ_TRACE_EN):
//   instr_done, instr_count[15:0]: retirement pulse and counter
module cpu_sequencer #(
   parameter int NUM_PHASES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       step_en,
   input  logic       step,
   input  logic       resume,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase,
   output logic       halted
`ifdef SEQ_TRACE_EN
   ,
   output logic        instr_done,
   output logic [15:0] instr_count
`endif
);

   generate
      if (NUM_PHASES != 8) begin : g_bad_phases
         $error("cpu_sequencer: NUM_PHASES must be 8");
      end
   endgenerate

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   phase_e r_phase;
   logic   r_halted;

   logic w_hlt;
   logic w_skz;
   logic w_sto;
   logic w_jmp;
   logic w_aluop;
   logic w_stall;

   assign w_hlt = (opcode == OP_HLT);
   assign w_skz = (opcode == OP_SKZ);
   assign w_sto = (opcode == OP_STO);
   assign w_jmp = (opcode == OP_JMP);
   assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

   // Step mode parks in phase 0 until a step pulse is seen there.
   assign w_stall = (r_phase == PH_INST_ADDR) && step_en && !step;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase  <= PH_INST_ADDR;
         r_halted <= 1'b0;
      end else if (r_halted) begin
         if (resume) begin
            r_halted <= 1'b0;
            r_phase  <= PH_INST_ADDR;
         end
      end else if (!w_stall) begin
         // HLT still moves to phase 5, then freezes there.
         if (r_phase == PH_OP_ADDR && w_hlt)
            r_halted <= 1'b1;
         r_phase <= phase_e'(r_phase + 3'd1);
      end
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      if (r_halted) begin
         halt = 1'b1;
      end else begin
         unique case (r_phase)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = w_hlt;
            end
            PH_OP_FETCH: begin
               rd = w_aluop;
            end
            PH_ALU_OP: begin
               rd     = w_aluop;
               inc_pc = w_skz && zero;
               ld_pc  = w_jmp;
               data_e = w_sto;
            end
            PH_STORE: begin
               rd     = w_aluop;
               ld_ac  = w_aluop;
               ld_pc  = w_jmp;
               wr     = w_sto;
               data_e = w_sto;
            end
         endcase
      end
   end

   assign phase  = r_phase;
   assign halted = r_halted;

`ifdef SEQ_TRACE_EN
   logic        r_done;
   logic [15:0] r_count;
   logic        w_retire;

   // An instruction retires when phase 7 completes or HLT halts.
   assign w_retire = !r_halted &&
                     ((r_phase == PH_STORE) ||
                      (r_phase == PH_OP_ADDR && w_hlt));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done  <= 1'b0;
         r_count <= 16'd0;
      end else begin
         r_done <= w_retire;
         if (w_retire)
            r_count <= r_count + 16'd1;
      end
   end

   assign instr_done  = r_done;
   assign instr_count = r_count;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer; a reference
// model predicts each cycle's outputs, a monitor checks the DUT.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = 3'd0;
   logic       zero = 1'b0;
   logic       step_en = 1'b0;
   logic       step = 1'b0;
   logic       resume = 1'b0;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;
   logic       halted;
`ifdef SEQ_TRACE_EN
   logic        instr_done;
   logic [15:0] instr_count;
`endif

   cpu_sequencer #(.NUM_PHASES(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .step_en(step_en), .step(step), .resume(resume),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
      .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e),
      .halt(halt), .phase(phase), .halted(halted)
`ifdef SEQ_TRACE_EN
      , .instr_done(instr_done), .instr_count(instr_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  ph;
      logic        hl;
      logic [8:0]  stb;
      logic        dn;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   // Reference model state (instruction-level view).
   int m_ph = 0;
   bit m_halt = 0;
   bit m_done = 0;
   int m_cnt = 0;

   // strobe order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
   function automatic logic [8:0] model_stb(int p, bit h, int op, bit z);
      bit alu, s, r, li, ip, lp, la, w, de, hh;
      alu = (op >= 2 && op <= 5);
      if (h) return 9'b000000001;
      s  = (p < 4);
      r  = (p >= 1 && p <= 3) || (p >= 5 && alu);
      li = (p == 2 || p == 3);
      ip = (p == 4) || (p == 6 && op == 1 && z);
      lp = (p >= 6 && op == 7);
      la = (p == 7 && alu);
      w  = (p == 7 && op == 6);
      de = (p >= 6 && op == 6);
      hh = (p == 4 && op == 0);
      return {s, r, li, ip, lp, la, w, de, hh};
   endfunction

   task automatic cyc(input bit r, input int op, input bit z,
                      input bit se, input bit st, input bit rs);
      exp_t e;
      @(negedge clk);
      rst = r; opcode = op[2:0]; zero = z;
      step_en = se; step = st; resume = rs;
      #1;
      e.ph  = m_ph[2:0];
      e.hl  = m_halt;
      e.stb = model_stb(m_ph, m_halt, op, z);
      e.dn  = m_done;
      e.cnt = m_cnt[15:0];
      q.push_back(e);
      // advance model to the state after the coming edge
      if (r) begin
         m_ph = 0; m_halt = 0; m_done = 0; m_cnt = 0;
      end else if (m_halt) begin
         m_done = 0;
         if (rs) begin m_halt = 0; m_ph = 0; end
      end else if (m_ph == 0 && se && !st) begin
         m_done = 0;
      end else if (m_ph == 4 && op == 0) begin
         m_halt = 1; m_ph = 5; m_done = 1;
         m_cnt = (m_cnt + 1) % 65536;
      end else if (m_ph == 7) begin
         m_ph = 0; m_done = 1;
         m_cnt = (m_cnt + 1) % 65536;
      end else begin
         m_ph = m_ph + 1; m_done = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want,
                  $time);
      end
   endtask

   // Monitor: pops one expectation per presented cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("phase", {13'd0, phase}, {13'd0, e.ph});
            chk("halted", {15'd0, halted}, {15'd0, e.hl});
            chk("strobes",
                {7'd0, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr,
                 data_e, halt},
                {7'd0, e.stb});
`ifdef SEQ_TRACE_EN
            chk("instr_done", {15'd0, instr_done}, {15'd0, e.dn});
            chk("instr_count", instr_count, e.cnt);
`endif
         end
      end
   end

   initial begin
      bit se;
      cyc(1, 2, 0, 0, 0, 0);
      cyc(1, 2, 0, 0, 0, 0);
      repeat (8) cyc(0, 2, 0, 0, 0, 0);   // ADD
      repeat (8) cyc(0, 1, 1, 0, 0, 0);   // SKZ zero=1
      repeat (8) cyc(0, 1, 0, 0, 0, 0);   // SKZ zero=0
      repeat (8) cyc(0, 6, 0, 0, 0, 0);   // STO
      repeat (8) cyc(0, 7, 0, 0, 0, 0);   // JMP
      repeat (15) cyc(0, 0, 0, 0, 0, 0);  // HLT then 10+ halted
      cyc(0, 0, 0, 0, 1, 1);              // resume beats step
      repeat (5) cyc(0, 2, 0, 1, 0, 0);   // step stall
      cyc(0, 2, 0, 1, 1, 0);
      repeat (12) cyc(0, 2, 1, 1, 0, 0);
      cyc(0, 2, 0, 0, 0, 0);              // release stall
      repeat (7) cyc(0, 3, 0, 0, 0, 0);
      repeat (6) cyc(0, 6, 0, 0, 0, 0);   // STO to Ph6
      cyc(1, 6, 0, 0, 0, 0);              // abort in Ph6
      repeat (24) cyc(0, 4, 0, 0, 0, 0);  // three instructions
      se = 0;
      repeat (600) begin
         if ($urandom_range(0, 99) < 5) se = ~se;
         cyc($urandom_range(0, 99) < 2, int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), se,
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 10);
      end
      @(negedge clk);
      #5;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
